matmul_array: RTL and testbench
===============================

# matmul_array

Parametrised N×N matrix multiplier, the next-generation matrix block for this datapath. It captures two N×N operand matrices on a Load pulse, computes C = A·B over N accumulate cycles with one processing element per output element, and presents a registered result with a one-cycle done pulse. Result width, signedness and overflow handling are configurable, so one block serves the 3×3/8-bit case and larger arrays.

## Interface
- N, default 3: matrix dimension, 2..8.
- DATA_W, default 8: operand element width.
- OUT_W, default 8: result element width, 1..ACC_W.
- SIGNED, default 0: 1 = two's-complement operands and results; 0 = unsigned.
- clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Load  input  1  start request; sampled only in IDLE.
- A_flat  input  N*N*DATA_W  operand A; element (i,j) at bits [(i*N+j)*DATA_W +: DATA_W].
- B_flat  input  N*N*DATA_W  operand B; same packing.
- Out_flat  output  N*N*OUT_W  result C; element (i,j) at bits [(i*N+j)*OUT_W +: OUT_W].
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when Out_flat updates.

## Operation
- States: IDLE, CALC.
- IDLE: busy=0. When Load=1 at an edge:
  - capture A_flat and B_flat into operand registers;
  - clear all accumulators;
  - set k=0 and go to CALC.
- CALC: busy=1. At each edge, every PE(i,j) adds A[i][k]·B[k][j] to its accumulator, then k increments.
- When k=N-1 in CALC, the same edge:
  - loads every result register from its final accumulated value;
  - sets done=1 for one cycle;
  - returns to IDLE.
- Load while busy=1 is ignored. It is not queued.
- Operands are sampled only at the capture edge. Input changes during CALC do not affect the result.
- Out_flat holds the last completed result until the next completion.
- Arithmetic:
  - products are 2*DATA_W wide;
  - accumulators are ACC_W = 2*DATA_W + clog2(N) bits, so they never overflow;
  - SIGNED selects sign extension for products and accumulators.
- Output reduction from ACC_W to OUT_W: see Configuration.

## Timing
- Reset (any state, including mid-CALC):
  - next state IDLE, k=0;
  - accumulators, operand registers and Out_flat = 0;
  - busy=0, done=0.
- Reset aborts an in-progress multiply. No done pulse follows it.
- Load accepted at edge E0. MAC edges are E1..EN. Result and done are registered at edge EN. done is high from EN to EN+1.
- busy is high from E0 to EN.
- Latency from accepted Load to valid Out_flat: N cycles. Minimum issue interval: N+1 cycles. A Load held high during the done cycle is accepted at edge EN+1.
- Load and Reset asserted at the same edge: Reset wins.

## Configuration
- SATURATE_EN defined: a full accumulator outside the OUT_W range clamps.
  - Unsigned range: 0..2^OUT_W-1.
  - Signed range: -2^(OUT_W-1)..2^(OUT_W-1)-1.
- SATURATE_EN undefined: the result is the low OUT_W bits of the accumulator (wrap-around).

## Structure
- Package matmul_pkg holds:
  - the ACC_W derivation function;
  - the state enum (IDLE, CALC);
  - index helpers for flat-bus packing.
- Sub-module matmul_pe: one accumulator per output element, with clear/enable/operand inputs, instantiated N×N by generate loops.
- The saturate/truncate stage sits inside matmul_pe, under the macro.
- The top level holds the FSM, the k counter, the operand registers and the per-k column/row select multiplexers.

## Test plan
- N=3, DATA_W=8, OUT_W=8, SIGNED=0. A = identity, B = 1..9 row-major, Load for one cycle: Out_flat = 1..9; done pulses exactly 3 cycles after the Load edge; busy is high for 3 cycles.
- All A and B elements 0x10: accumulator = 768; Out = 0x00 without SATURATE_EN, 0xFF with SATURATE_EN.
- SIGNED=1. A = -1·identity (0xFF diagonal), B all 0x05: every Out element = 0xFB (-5).
- Load re-asserted at cycle 1 of CALC with different operands: ignored; result matches the first operands; the next Load, during the done cycle, starts a new run at the following edge.
- Reset asserted at the second CALC edge: Out = 0, busy=0, no done pulse; a subsequent Load computes correctly from clear accumulators.
- N=4, DATA_W=4, OUT_W=10. All elements 0xF: every Out element = 900, done pulses 4 cycles after the Load edge.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul_array block: accumulator width, FSM states
// and the flat-bus element index used for the operand and result packing.
package matmul_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Wide enough that N full-scale products can be summed without overflow.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned n);
    return 2 * data_w + $clog2(n);
  endfunction

  function automatic int unsigned elem_lsb(input int unsigned row, input int unsigned col,
                                           input int unsigned n, input int unsigned w);
    return (row * n + col) * w;
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Operand/result bundle of matmul_array; master drives Load and operands, slave returns results.
interface matmul_if #(
  parameter int unsigned N      = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 8
);
  logic                      Load;
  logic [N*N*DATA_W-1:0]     A_flat;
  logic [N*N*DATA_W-1:0]     B_flat;
  logic [N*N*OUT_W-1:0]      Out_flat;
  logic                      busy;
  logic                      done;

  modport master (output Load, A_flat, B_flat, input Out_flat, busy, done);
  modport slave  (input Load, A_flat, B_flat, output Out_flat, busy, done);
endinterface

// File: rtl/matmul_pe.sv
// One output element of matmul_array: multiply-accumulate plus the result register.
// Optional feature: SATURATE_EN clamps out-of-range results instead of wrapping.
module matmul_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 18,
  parameter int unsigned OUT_W  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              clr,
  input  logic              en,
  input  logic              last,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OUT_W-1:0]  res
);
  localparam int unsigned PW = 2 * DATA_W;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [OUT_W-1:0] res_next;

  generate
    if (SIGNED) begin : g_signed
      logic signed [PW-1:0] p_s;
      assign p_s      = PW'($signed(a)) * PW'($signed(b));
      assign prod_ext = {{(ACC_W-PW){p_s[PW-1]}}, p_s};
    end else begin : g_unsigned
      logic [PW-1:0] p_u;
      assign p_u      = PW'(a) * PW'(b);
      assign prod_ext = {{(ACC_W-PW){1'b0}}, p_u};
    end
  endgenerate

  assign acc_next = acc + prod_ext;

  generate
    if (OUT_W == ACC_W) begin : g_full
      assign res_next = acc_next;
    end else begin : g_reduce
`ifdef SATURATE_EN
      if (SIGNED) begin : g_sat_s
        // In range only when every bit above the output sign bit matches it.
        logic             in_range;
        logic [OUT_W-1:0] min_v;
        assign in_range = (&acc_next[ACC_W-1:OUT_W-1]) || !(|acc_next[ACC_W-1:OUT_W-1]);
        assign min_v    = OUT_W'(1) << (OUT_W - 1);
        assign res_next = in_range ? acc_next[OUT_W-1:0] :
                          acc_next[ACC_W-1] ? min_v : ~min_v;
      end else begin : g_sat_u
        assign res_next = (|acc_next[ACC_W-1:OUT_W]) ? '1 : acc_next[OUT_W-1:0];
      end
`else
      assign res_next = acc_next[OUT_W-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (Reset) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (en)
        acc <= acc_next;
      if (last)
        res <= res_next;
    end
  end

endmodule

// File: rtl/matmul_array.sv
// N x N matrix multiplier C = A.B: operand capture, k sequencing and an N x N PE grid.
// Optional feature: SATURATE_EN (see matmul_pe) selects clamping of the result elements.
module matmul_array
  import matmul_pkg::*;
#(
  parameter int unsigned N      = 3,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OUT_W  = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic      clk,
  input  logic      Reset,
  matmul_if.slave   bus
);
  localparam int unsigned ACC_W = acc_width(DATA_W, N);
  localparam int unsigned KW    = $clog2(N);
  localparam int unsigned OPW   = N * N * DATA_W;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [OPW-1:0]    a_q, b_q;
  logic              done_q;
  logic              capture, en, last;
  logic [DATA_W-1:0] a_sel [N];
  logic [DATA_W-1:0] b_sel [N];
  logic [N*N*OUT_W-1:0] out_flat;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    capture = 1'b0;
    en      = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Load) begin
          capture = 1'b1;
          k_d     = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        en = 1'b1;
        if (k_q == KW'(N - 1)) begin
          last    = 1'b1;
          k_d     = '0;
          state_d = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= last;
      if (capture) begin
        a_q <= bus.A_flat;
        b_q <= bus.B_flat;
      end
    end
  end

  // Row r of the grid sees A[r][k]; column r sees B[k][r].
  always_comb begin
    for (int unsigned r = 0; r < N; r++) begin
      a_sel[r] = a_q[elem_lsb(r, 32'(k_q), N, DATA_W) +: DATA_W];
      b_sel[r] = b_q[elem_lsb(32'(k_q), r, N, DATA_W) +: DATA_W];
    end
  end

  generate
    for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
        matmul_pe #(
          .DATA_W (DATA_W),
          .ACC_W  (ACC_W),
          .OUT_W  (OUT_W),
          .SIGNED (SIGNED)
        ) u_pe (
          .clk   (clk),
          .Reset (Reset),
          .clr   (capture),
          .en    (en),
          .last  (last),
          .a     (a_sel[i]),
          .b     (b_sel[j]),
          .res   (out_flat[elem_lsb(i, j, N, OUT_W) +: OUT_W])
        );
      end
    end
  endgenerate

  assign bus.Out_flat = out_flat;
  assign bus.busy     = (state_q == CALC);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_matmul_array.sv
// Scoreboard bench for matmul_array: three configurations (3x3 unsigned, 3x3 signed, 4x4/4-bit).
module tb_matmul_array;

  typedef logic [159:0] vec_t;
  typedef logic [255:0] opd_t;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  matmul_if #(.N(3), .DATA_W(8), .OUT_W(8))  if0 ();
  matmul_if #(.N(3), .DATA_W(8), .OUT_W(8))  if1 ();
  matmul_if #(.N(4), .DATA_W(4), .OUT_W(10)) if2 ();

  matmul_array #(.N(3), .DATA_W(8), .OUT_W(8), .SIGNED(1'b0))
    u0 (.clk(clk), .Reset(Reset), .bus(if0));
  matmul_array #(.N(3), .DATA_W(8), .OUT_W(8), .SIGNED(1'b1))
    u1 (.clk(clk), .Reset(Reset), .bus(if1));
  matmul_array #(.N(4), .DATA_W(4), .OUT_W(10), .SIGNED(1'b0))
    u2 (.clk(clk), .Reset(Reset), .bus(if2));

  int n_checks = 0;
  int n_errors = 0;
  vec_t q0[$], q1[$], q2[$];

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 0 = diagonal of v, 1 = 1..N*N row-major, 2 = all v, 3 = random
  function automatic opd_t mk(input int n, input int dw, input int kind, input longint v);
    opd_t   r = '0;
    longint val;
    for (int e = 0; e < n * n; e++) begin
      case (kind)
        0:       val = ((e / n) == (e % n)) ? v : 0;
        1:       val = e + 1;
        2:       val = v;
        default: val = longint'($urandom);
      endcase
      val = val & ((longint'(1) << dw) - 1);
      r   = r | (opd_t'(val) << (e * dw));
    end
    return r;
  endfunction

  function automatic longint elem(input opd_t x, input int off, input int dw, input bit sgn);
    opd_t   t = x >> off;
    longint v = longint'(t[63:0]) & ((longint'(1) << dw) - 1);
    if (sgn && v >= (longint'(1) << (dw - 1)))
      v = v - (longint'(1) << dw);
    return v;
  endfunction

  function automatic vec_t model(input int n, input int dw, input int ow, input bit sgn,
                                 input opd_t a, input opd_t b);
    vec_t   r = '0;
    longint acc, lo, hi;
    longint m = (longint'(1) << ow) - 1;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        acc = 0;
        for (int k = 0; k < n; k++)
          acc += elem(a, (i*n+k)*dw, dw, sgn) * elem(b, (k*n+j)*dw, dw, sgn);
`ifdef SATURATE_EN
        if (sgn) begin
          lo = -(longint'(1) << (ow - 1));
          hi = (longint'(1) << (ow - 1)) - 1;
        end else begin
          lo = 0;
          hi = m;
        end
        if (acc < lo) acc = lo;
        if (acc > hi) acc = hi;
`else
        lo = 0;
        hi = 0;
`endif
        r = r | (vec_t'(acc & m) << ((i*n+j)*ow));
      end
    end
    return r;
  endfunction

  function automatic vec_t all_elems(input int count, input int ow, input longint v);
    vec_t r = '0;
    for (int e = 0; e < count; e++)
      r = r | (vec_t'(v & ((longint'(1) << ow) - 1)) << (e * ow));
    return r;
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  always @(negedge clk) if (if0.done === 1'b1) begin
    if (q0.size() == 0) check("sb0_spurious_done", 1, 0);
    else                check("sb0_result", if0.Out_flat, q0.pop_front());
  end
  always @(negedge clk) if (if1.done === 1'b1) begin
    if (q1.size() == 0) check("sb1_spurious_done", 1, 0);
    else                check("sb1_result", if1.Out_flat, q1.pop_front());
  end
  always @(negedge clk) if (if2.done === 1'b1) begin
    if (q2.size() == 0) check("sb2_spurious_done", 1, 0);
    else                check("sb2_result", if2.Out_flat, q2.pop_front());
  end

  task automatic set_ops(input int d, input opd_t a, input opd_t b, input logic ld);
    case (d)
      0: begin if0.A_flat = a[71:0]; if0.B_flat = b[71:0]; if0.Load = ld; end
      1: begin if1.A_flat = a[71:0]; if1.B_flat = b[71:0]; if1.Load = ld; end
      default: begin if2.A_flat = a[63:0]; if2.B_flat = b[63:0]; if2.Load = ld; end
    endcase
  endtask

  task automatic push_exp(input int d, input opd_t a, input opd_t b);
    case (d)
      0:       q0.push_back(model(3, 8, 8, 1'b0, a, b));
      1:       q1.push_back(model(3, 8, 8, 1'b1, a, b));
      default: q2.push_back(model(4, 4, 10, 1'b0, a, b));
    endcase
  endtask

  // Drives a one-cycle Load; returns at accept edge + 1.
  task automatic load(input int d, input opd_t a, input opd_t b, input bit accepted);
    @(negedge clk);
    set_ops(d, a, b, 1'b1);
    if (accepted) push_exp(d, a, b);
    @(posedge clk);
    #1;
    case (d)
      0:       if0.Load = 1'b0;
      1:       if1.Load = 1'b0;
      default: if2.Load = 1'b0;
    endcase
  endtask

  task automatic wait_done(input int d, input string tag, output int lat, output int bc);
    lat = 0;
    bc  = get_busy(d) ? 1 : 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (get_done(d) === 1'b1) break;
      if (get_busy(d) === 1'b1) bc++;
    end
    if (lat >= 40) check({tag, "_timeout"}, 0, 1);
  endtask

  opd_t a, b, a2, b2;
  int   lat, bc;
  vec_t exp_v;

  initial begin
    Reset = 1'b1;
    set_ops(0, '0, '0, 1'b0);
    set_ops(1, '0, '0, 1'b0);
    set_ops(2, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out0", if0.Out_flat, 0);
    check("rst_out2", if2.Out_flat, 0);
    check("rst_busy0", if0.busy, 0);
    check("rst_done0", if0.done, 0);
    check("rst_busy2", if2.busy, 0);
    Reset = 1'b0;

    // identity x 1..9
    a = mk(3, 8, 0, 1);
    b = mk(3, 8, 1, 0);
    load(0, a, b, 1'b1);
    wait_done(0, "t1", lat, bc);
    check("t1_latency", lat, 3);
    check("t1_busy_cycles", bc, 3);
    exp_v = '0;
    for (int e = 0; e < 9; e++) exp_v = exp_v | (vec_t'(e + 1) << (e * 8));
    check("t1_out", if0.Out_flat, exp_v);
    @(posedge clk); #1;
    check("t1_done_pulse", if0.done, 0);
    check("t1_out_hold", if0.Out_flat, exp_v);

    // overflowing sums: 3 * 0x10 * 0x10 = 768
    a = mk(3, 8, 2, 'h10);
    load(0, a, a, 1'b1);
    wait_done(0, "t2", lat, bc);
    check("t2_latency", lat, 3);
`ifdef SATURATE_EN
    check("t2_out", if0.Out_flat, all_elems(9, 8, 'hFF));
`else
    check("t2_out", if0.Out_flat, all_elems(9, 8, 'h00));
`endif

    // signed: -I x all 5
    a = mk(3, 8, 0, 'hFF);
    b = mk(3, 8, 2, 5);
    load(1, a, b, 1'b1);
    wait_done(1, "t3", lat, bc);
    check("t3_out", if1.Out_flat, all_elems(9, 8, 'hFB));
    a = mk(3, 8, 3, 0);
    b = mk(3, 8, 3, 0);
    load(1, a, b, 1'b1);
    wait_done(1, "t3r", lat, bc);
    check("t3r_latency", lat, 3);

    // Load during CALC ignored; Load in the done cycle accepted on the next edge
    a = mk(3, 8, 3, 0);
    b = mk(3, 8, 3, 0);
    load(0, a, b, 1'b1);
    @(negedge clk);
    set_ops(0, mk(3, 8, 3, 0), mk(3, 8, 3, 0), 1'b1);
    @(posedge clk); #1;
    if0.Load = 1'b0;
    check("t4_busy_mid", if0.busy, 1);
    wait_done(0, "t4", lat, bc);
    check("t4_latency_rest", lat, 2);
    a2 = mk(3, 8, 3, 0);
    b2 = mk(3, 8, 3, 0);
    set_ops(0, a2, b2, 1'b1);
    push_exp(0, a2, b2);
    @(posedge clk); #1;
    if0.Load = 1'b0;
    check("t4_reissue_busy", if0.busy, 1);
    wait_done(0, "t4b", lat, bc);
    check("t4b_latency", lat, 3);

    // Reset at the second CALC edge aborts the run
    load(0, mk(3, 8, 2, 7), mk(3, 8, 2, 9), 1'b0);
    @(posedge clk); #1;
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    check("t5_out_clear", if0.Out_flat, 0);
    check("t5_busy", if0.busy, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("t5_no_done", if0.done, 0);
    end
    a = mk(3, 8, 3, 0);
    b = mk(3, 8, 3, 0);
    load(0, a, b, 1'b1);
    wait_done(0, "t5b", lat, bc);
    check("t5b_latency", lat, 3);

    // Load and Reset at the same edge
    @(negedge clk);
    Reset = 1'b1;
    if0.Load = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    if0.Load = 1'b0;
    check("t6_rst_wins", if0.busy, 0);

    // 4x4, 4-bit: 4 * 15 * 15 = 900
    a = mk(4, 4, 2, 'hF);
    load(2, a, a, 1'b1);
    wait_done(2, "t7", lat, bc);
    check("t7_latency", lat, 4);
    check("t7_busy_cycles", bc, 4);
    check("t7_out", if2.Out_flat, all_elems(16, 10, 900));
    a = mk(4, 4, 3, 0);
    b = mk(4, 4, 3, 0);
    load(2, a, b, 1'b1);
    wait_done(2, "t7r", lat, bc);

    repeat (3) @(posedge clk);
    #1;
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    check("drain_q2", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
